// File: rtl/lshift_load_seq_if.sv
// +----------------------------------------------------------------------+
// | lshift_load_seq_if : request handshake and shift-register load bus    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface lshift_load_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_val;
  logic [CNT_W-1:0] req_run;
  logic             abort;
  logic [WIDTH-1:0] load_val;
  logic             load_en;
  logic             busy;
  logic             done;
  logic [15:0]      load_count;

  modport master (
    output req_valid, req_val, req_run, abort,
    input  req_ready, load_val, load_en, busy, done, load_count
  );

  modport slave (
    input  req_valid, req_val, req_run, abort,
    output req_ready, load_val, load_en, busy, done, load_count
  );
endinterface

`default_nettype wire

// File: rtl/lshift_load_seq.sv
// +----------------------------------------------------------------------+
// | lshift_load_seq : one load_en pulse per request, then a timed run     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module lshift_load_seq #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_RUN = 20
) (
  input  logic              clk,
  input  logic              rstn,
  lshift_load_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_DEFAULT_RUN = CNT_W'(DEFAULT_RUN);
  localparam logic [CNT_W-1:0] C_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] load_val_q;
  logic             load_en_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      load_count_q;

  logic [CNT_W-1:0] run_d;
  logic [15:0]      load_count_d;

  assign run_d        = (bus.req_run == '0) ? C_DEFAULT_RUN : bus.req_run;
  assign load_count_d = (load_count_q == 16'hFFFF) ? load_count_q : load_count_q + 16'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      load_val_q   <= '0;
      load_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
      load_count_q <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && ready_q && !bus.abort) begin
            load_val_q <= bus.req_val;
            load_en_q  <= 1'b1;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            cnt_q      <= run_d;
            state_q    <= ST_LOAD;
          end else begin
            // Also raises ready on the first edge after reset release.
            ready_q <= 1'b1;
          end
        end

        ST_LOAD: begin
          load_en_q    <= 1'b0;
          load_count_q <= load_count_d;
          if (bus.abort) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q == C_ONE) begin
            done_q <= 1'b1;
            // A waiting request is taken on the completion edge itself.
            if (bus.req_valid) begin
              load_val_q <= bus.req_val;
              load_en_q  <= 1'b1;
              cnt_q      <= run_d;
              state_q    <= ST_LOAD;
            end else begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - C_ONE;
          end
        end

        default: begin
          load_en_q <= 1'b0;
          busy_q    <= 1'b0;
          ready_q   <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.load_val   = load_val_q;
  assign bus.load_en    = load_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_count = load_count_q;

endmodule

`default_nettype wire

// File: tb/tb_lshift_load_seq.sv
// +----------------------------------------------------------------------+
// | tb_lshift_load_seq : scoreboard bench for the load sequencer          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lshift_load_seq;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_vec;
  int   n_err;

  typedef struct {
    logic [7:0] val;
    int         run;
    bit         want_done;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  lshift_load_seq_if #(.WIDTH(8), .CNT_W(8)) bus ();

  lshift_load_seq #(.WIDTH(8), .CNT_W(8), .DEFAULT_RUN(20)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each observed load pops its expected value; completion timing is queued from it.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (bus.load_en) begin
        if (exp_q.size() == 0) begin
          check("load_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("load_val", {24'd0, bus.load_val}, {24'd0, e.val});
          if (e.want_done)
            done_q.push_back(cyc + ((e.run == 0) ? 20 : e.run) + 1);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else                    check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] v, input logic [7:0] r, input bit want_done,
                      output int pcyc);
    exp_t e;
    bit   seen;
    seen        = 1'b0;
    e.val       = v;
    e.run       = int'(r);
    e.want_done = want_done;
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_val   = v;
    bus.req_run   = r;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.load_en) seen = 1'b1;
    end
    pcyc = cyc;
    if (!seen) check("accept_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300 && bus.busy; i++) @(negedge clk);
    if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic single_load(input logic [7:0] v, input int exp_count);
    int p;
    int bc;
    send(v, 8'd0, 1'b1, p);
    bc = 1;
    for (int i = 0; i < 100 && bus.busy; i++) begin
      @(negedge clk);
      if (i == 0) check("load_en_width", {31'd0, bus.load_en}, 32'd0);
      if (bus.busy) bc++;
    end
    check("busy_cycles", bc, 32'd21);
    @(negedge clk);
    check("ready_after_done", {31'd0, bus.req_ready}, 32'd1);
    check("load_count", {16'd0, bus.load_count}, exp_count);
  endtask

  initial begin
    int p1;
    int p2;
    n_vec         = 0;
    n_err         = 0;
    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_val   = 8'h00;
    bus.req_run   = 8'h00;
    bus.abort     = 1'b0;

    // Reset
    repeat (2) begin
      @(negedge clk);
      check("rst_load_en", {31'd0, bus.load_en}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rst_count", {16'd0, bus.load_count}, 32'd0);
    end
    rstn = 1'b1;
    #1 check("ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_release", {31'd0, bus.req_ready}, 32'd1);

    // Single load with default run length
    single_load(8'h01, 1);

    // Back-to-back with req_valid held
    send(8'h81, 8'd3, 1'b1, p1);
    send(8'h0F, 8'd1, 1'b1, p2);
    check("b2b_gap", p2 - p1, 32'd4);
    wait_idle();
    @(negedge clk);
    check("b2b_count", {16'd0, bus.load_count}, 32'd3);

    // Abort in RUN cycle 4
    send(8'hA5, 8'd10, 1'b0, p1);
    repeat (4) @(negedge clk);
    check("run_busy_pre_abort", {31'd0, bus.busy}, 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_load_val", {24'd0, bus.load_val}, 32'hA5);
    repeat (10) @(negedge clk);
    check("abort_count", {16'd0, bus.load_count}, 32'd4);

    // Abort and request together in IDLE
    begin
      exp_t e;
      e.val = 8'h3C; e.run = 2; e.want_done = 1'b1;
      exp_q.push_back(e);
    end
    bus.req_valid = 1'b1;
    bus.req_val   = 8'h3C;
    bus.req_run   = 8'd2;
    bus.abort     = 1'b1;
    @(negedge clk);
    check("idle_abort_no_load", {31'd0, bus.load_en}, 32'd0);
    check("idle_abort_no_busy", {31'd0, bus.busy}, 32'd0);
    bus.abort = 1'b0;
    @(negedge clk);
    check("idle_abort_then_load", {31'd0, bus.load_en}, 32'd1);
    bus.req_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("idle_abort_count", {16'd0, bus.load_count}, 32'd5);

    // Asynchronous reset mid-RUN
    send(8'h55, 8'd6, 1'b0, p1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("areset_busy", {31'd0, bus.busy}, 32'd0);
    check("areset_ready", {31'd0, bus.req_ready}, 32'd0);
    check("areset_count", {16'd0, bus.load_count}, 32'd0);
    check("areset_load_val", {24'd0, bus.load_val}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("areset_ready_release", {31'd0, bus.req_ready}, 32'd1);
    single_load(8'h01, 1);

    repeat (3) @(negedge clk);
    check("loads_outstanding", exp_q.size(), 32'd0);
    check("done_outstanding", done_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
